// File: rtl/alu_pkg.sv
// Shared opcode definitions for the registered ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOR = 3'b101,
    OP_SLT = 3'b110,
    OP_SHL = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum, carry-or-borrow, signed less-than and,
// when ALU_FLAGS_EN is defined, signed overflow.
module alu_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
`ifdef ALU_FLAGS_EN
  output logic             overflow,
`endif
  output logic             less
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;
  logic             ovf;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  // Subtraction produces carry=1 when no borrow occurs, so invert it.
  assign carry = full[WIDTH] ^ sub;
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign less  = sum[WIDTH-1] ^ ovf;

`ifdef ALU_FLAGS_EN
  assign overflow = ovf;
`endif

endmodule

// File: rtl/alu.sv
// One-cycle registered ALU. Define ALU_FLAGS_EN to add the registered
// Zero and Overflow outputs.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_Out,
`ifdef ALU_FLAGS_EN
  output logic             Zero,
  output logic             Overflow,
`endif
  output logic             CarryOut
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_op_e          op;
  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_less;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   shl_full;
  logic [WIDTH-1:0] res;
  logic             cy;

  assign op     = alu_op_e'(ALU_Sel);
  assign as_sub = (op == OP_SUB) || (op == OP_SLT);

`ifdef ALU_FLAGS_EN
  logic as_ovf;
  logic ov;
`endif

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (A),
    .b        (B),
    .sub      (as_sub),
    .sum      (as_sum),
    .carry    (as_carry),
`ifdef ALU_FLAGS_EN
    .overflow (as_ovf),
`endif
    .less     (as_less)
  );

  // Bit WIDTH of the widened shift is the last bit shifted out (0 for shamt=0).
  assign shamt    = B[SHW-1:0];
  assign shl_full = {1'b0, A} << shamt;

  always_comb begin
    res = '0;
    cy  = 1'b0;
    unique case (op)
      OP_ADD: begin res = as_sum; cy = as_carry; end
      OP_SUB: begin res = as_sum; cy = as_carry; end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOR: res = ~(A | B);
      OP_SLT: res = {{(WIDTH-1){1'b0}}, as_less};
      OP_SHL: begin res = shl_full[WIDTH-1:0]; cy = shl_full[WIDTH]; end
      default: begin res = '0; cy = 1'b0; end
    endcase
  end

`ifdef ALU_FLAGS_EN
  assign ov = ((op == OP_ADD) || (op == OP_SUB)) ? as_ovf : 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ALU_Out   <= '0;
      CarryOut  <= 1'b0;
`ifdef ALU_FLAGS_EN
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALU_Out  <= res;
        CarryOut <= cy;
`ifdef ALU_FLAGS_EN
        Zero     <= (res == '0);
        Overflow <= ov;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model plus literal vectors.
module tb_alu;
  localparam int W = 8;
  localparam longint MASK = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   ALU_Sel = 3'd0;
  logic         out_valid;
  logic [W-1:0] ALU_Out;
  logic         CarryOut;
`ifdef ALU_FLAGS_EN
  logic         Zero;
  logic         Overflow;
`endif

  int tests = 0;
  int fails = 0;

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .ALU_Out   (ALU_Out),
`ifdef ALU_FLAGS_EN
    .Zero      (Zero),
    .Overflow  (Overflow),
`endif
    .CarryOut  (CarryOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint to_signed(input longint v);
    return (v >= (64'd1 << (W - 1))) ? v - (64'd1 << W) : v;
  endfunction

  // Reference behaviour from plain integer arithmetic.
  task automatic model_op(input int op, input longint a, input longint b,
                          output longint r, output bit c, output bit z, output bit v);
    longint s;
    int sh;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin
        s = a + b; r = s & MASK; c = (s > MASK);
        s = to_signed(a) + to_signed(b);
        v = (s > (64'd1 << (W - 1)) - 1) || (s < -(64'sd1 <<< (W - 1)));
      end
      1: begin
        r = (a - b) & MASK; c = (a < b);
        s = to_signed(a) - to_signed(b);
        v = (s > (64'd1 << (W - 1)) - 1) || (s < -(64'sd1 <<< (W - 1)));
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~(a | b)) & MASK;
      6: r = (to_signed(a) < to_signed(b)) ? 1 : 0;
      default: begin
        sh = int'(b % W);
        r = (a << sh) & MASK;
        c = (sh == 0) ? 1'b0 : bit'((a >> (W - sh)) & 1);
      end
    endcase
    z = (r == 0);
  endtask

  longint m_out = 0;
  bit     m_c = 1'b0, m_z = 1'b0, m_v = 1'b0, m_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    longint r;
    bit c, z, v;
    if (!rst_n) begin
      m_valid <= 1'b0; m_out <= 0; m_c <= 1'b0; m_z <= 1'b0; m_v <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        model_op(int'(ALU_Sel), longint'(A), longint'(B), r, c, z, v);
        m_out <= r; m_c <= c; m_z <= z; m_v <= v;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc out_valid", longint'(out_valid), longint'(m_valid));
      chk("cyc ALU_Out", longint'(ALU_Out), m_out);
      chk("cyc CarryOut", longint'(CarryOut), longint'(m_c));
`ifdef ALU_FLAGS_EN
      chk("cyc Zero", longint'(Zero), longint'(m_z));
      chk("cyc Overflow", longint'(Overflow), longint'(m_v));
`endif
    end
  end

  task automatic vec(input string name, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input longint eo, input bit ec,
                     input bit ez, input bit ev);
    @(negedge clk);
    in_valid = 1'b1; ALU_Sel = op; A = a; B = b;
    @(posedge clk);
    #1;
    chk({name, " out_valid"}, longint'(out_valid), 1);
    chk({name, " ALU_Out"}, longint'(ALU_Out), eo);
    chk({name, " CarryOut"}, longint'(CarryOut), longint'(ec));
    chk({name, " model"}, m_out, eo);
`ifdef ALU_FLAGS_EN
    chk({name, " Zero"}, longint'(Zero), longint'(ez));
    chk({name, " Overflow"}, longint'(Overflow), longint'(ev));
`else
    if (ez && ev) chk({name, " model zv"}, longint'(m_z), 1);
`endif
  endtask

  initial begin
    #2;
    chk("reset ALU_Out", longint'(ALU_Out), 0);
    chk("reset CarryOut", longint'(CarryOut), 0);
    chk("reset out_valid", longint'(out_valid), 0);
    #10 rst_n = 1'b1;

    vec("add ff+01", 3'b000, 8'hFF, 8'h01, 'h00, 1, 1, 0);
    vec("sub 05-07", 3'b001, 8'h05, 8'h07, 'hFE, 1, 0, 0);
    vec("add 7f+01", 3'b000, 8'h7F, 8'h01, 'h80, 0, 0, 1);
    vec("sub 80-01", 3'b001, 8'h80, 8'h01, 'h7F, 0, 0, 1);
    vec("slt 80<01", 3'b110, 8'h80, 8'h01, 'h01, 0, 0, 0);
    vec("slt 01<80", 3'b110, 8'h01, 8'h80, 'h00, 0, 1, 0);
    vec("shl 81<<1", 3'b111, 8'h81, 8'h01, 'h02, 1, 0, 0);
    vec("shl 81<<0", 3'b111, 8'h81, 8'h00, 'h81, 0, 0, 0);
    vec("shl 81<<9", 3'b111, 8'h81, 8'h09, 'h02, 1, 0, 0);
    vec("shl 41<<7", 3'b111, 8'h41, 8'h07, 'h80, 0, 0, 0);
    vec("and", 3'b010, 8'hCC, 8'hAA, 'h88, 0, 0, 0);
    vec("or", 3'b011, 8'hC0, 8'h0A, 'hCA, 0, 0, 0);
    vec("xor", 3'b100, 8'hFF, 8'h0F, 'hF0, 0, 0, 0);
    vec("sub eq", 3'b001, 8'h33, 8'h33, 'h00, 0, 1, 0);
    vec("nor f0|0f", 3'b101, 8'hF0, 8'h0F, 'h00, 0, 1, 0);

    // Idle: inputs change but outputs must hold.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; A = 8'(8'h11 * (i + 1)); B = 8'h5A; ALU_Sel = 3'b000;
      @(posedge clk);
      #1;
      chk("idle out_valid", longint'(out_valid), 0);
      chk("idle ALU_Out", longint'(ALU_Out), 0);
      chk("idle CarryOut", longint'(CarryOut), 0);
    end

    // Back-to-back traffic checked by the model each cycle.
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      A = 8'($urandom); B = 8'($urandom); ALU_Sel = 3'($urandom);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle after a valid ADD.
    vec("add pre-rst", 3'b000, 8'hF0, 8'h20, 'h10, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst ALU_Out", longint'(ALU_Out), 0);
    chk("rst CarryOut", longint'(CarryOut), 0);
    chk("rst out_valid", longint'(out_valid), 0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    vec("add post-rst", 3'b000, 8'h12, 8'h34, 'h46, 0, 0, 0);

    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
